seq_detect_prog: RTL

Programmable serial bit-pattern detector with a Moore-style output. It is the parametrised successor of the team's fixed 1011 overlapping detector. Pattern, pattern length and overlap/non-overlap mode are loadable at run time, and a saturating match counter is included. It sits on a 1-bit serial input stream with a qualifying enable and produces a registered one-cycle match pulse for downstream framing/sync logic.

---
 rtl/seq_detect_prog.sv | 110 +++++++++++
 1 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector: loadable pattern, length and overlap mode,
// with a registered match pulse and a saturating match counter.
module seq_detect_prog #(
    parameter int LEN   = 8,
    parameter int CNT_W = 8,
    parameter int LW    = $clog2(LEN + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN,
    input  logic             EN,
    input  logic             PAT_LD,
    input  logic [LEN-1:0]   PAT,
    input  logic [LW-1:0]    PAT_LEN,
    input  logic             OVL_IN,
    input  logic             CNT_CLR,
    output logic             OUT,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic             LD_ERR
);

    localparam logic [LW-1:0]    LEN_L    = LW'(LEN);
    localparam logic [LW-1:0]    PLEN_RST = LW'(4);
    localparam logic [LEN-1:0]   PAT_RST  = LEN'(4'b1011);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [LEN-1:0]   pat_q,  pat_d;
    logic [LW-1:0]    plen_q, plen_d;
    logic             ovl_q,  ovl_d;
    logic [LEN-1:0]   hist_q, hist_d;
    logic [LW-1:0]    fill_q, fill_d;
    logic             out_q,  out_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             err_q,  err_d;

    logic             ld_valid;
    logic             ld_bad;
    logic             sample;
    logic [LEN-1:0]   hist_nx;
    logic [LW-1:0]    fill_nx;
    logic [LEN-1:0]   len_mask;
    logic             match;

    // A valid load takes priority over the serial bit in the same cycle.
    assign ld_valid = PAT_LD && (PAT_LEN != '0) && (PAT_LEN <= LEN_L);
    assign ld_bad   = PAT_LD && !ld_valid;
    assign sample   = EN && !ld_valid;

    assign hist_nx  = {hist_q[LEN-2:0], IN};
    assign fill_nx  = (fill_q == LEN_L) ? fill_q : fill_q + LW'(1);
    assign len_mask = ~({LEN{1'b1}} << plen_q);
    assign match    = sample && (fill_nx >= plen_q)
                      && (((hist_nx ^ pat_q) & len_mask) == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pat_q  <= PAT_RST;
            plen_q <= PLEN_RST;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            plen_q <= plen_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        plen_d = plen_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (ld_valid) begin
            pat_d  = PAT;
            plen_d = PAT_LEN;
            ovl_d  = OVL_IN;
            hist_d = '0;
            fill_d = '0;
        end else if (sample) begin
            hist_d = hist_nx;
            // Non-overlapping mode discards history once it has been consumed by a match.
            fill_d = (match && !ovl_q) ? '0 : fill_nx;
        end
    end

    always_comb begin
        out_d = match;
        err_d = ld_bad;
        cnt_d = cnt_q;
        if (CNT_CLR)
            cnt_d = '0;
        else if (match && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign OUT       = out_q;
    assign MATCH_CNT = cnt_q;
    assign LD_ERR    = err_q;

endmodule
